// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit scheduler.
// The default watchdog covers one full 8N1 frame plus a bit time and a margin.
package uart_pkg;

    localparam int CLK_FREQ       = 100_000_000;
    localparam int BAUD           = 9600;
    localparam int BIT_CYCLES     = 10417;
    localparam int FRAME_BITS     = 10;
    localparam int TIMEOUT_MARGIN = 5413;
    localparam int DEFAULT_TIMEOUT_CYCLES = (FRAME_BITS + 1) * BIT_CYCLES + TIMEOUT_MARGIN;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE,
        ST_GAP
    } sched_state_t;

    // Counter widths never collapse to zero bits, even for degenerate parameters.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request bit starting at rr_ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    int idx;

    // Scan from farthest to nearest so the candidate closest to rr_ptr is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                winner = PTR_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte sources in round-robin order,
// with an optional inter-frame gap and a per-frame watchdog.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int PTR_W  = clog2_min1(NUM_REQ);
    localparam int WDOG_W = clog2_min1(TIMEOUT_CYCLES);
    localparam int GAP_W  = clog2_min1(GAP_CYCLES + 1);

    sched_state_t       state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic [PTR_W-1:0]   arb_winner;
    logic               arb_valid;
    logic [PTR_W-1:0]   next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        wdog_d     = wdog_q;
        gap_d      = gap_q;
        tx_data_d  = tx_data_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        next_ptr   = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid && !tx_busy) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (PTR_W'(i) == arb_winner) begin
                            tx_data_d = req_data[8*i +: 8];
                            ack_d[i]  = 1'b1;
                        end
                    end
                    win_d   = arb_winner;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_start_d = 1'b1;
                wdog_d     = '0;
                state_d    = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    rr_ptr_d = next_ptr;
                    if (GAP_CYCLES > 0) begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // A reset mid-frame abandons the frame outright; the source was already acked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            win_q      <= '0;
            wdog_q     <= '0;
            gap_q      <= '0;
            tx_data_q  <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            wdog_q     <= wdog_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ack         = ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: expected (source, byte) grants are queued when a source is loaded
// and popped when the scheduler acks; a second instance exercises the inter-frame gap.
module tb_uart_tx_scheduler;

    localparam int TOUT   = 200;
    localparam int TX_LAT = 40;
    localparam int GAP    = 50;

    typedef struct {
        int         src;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic        busy;
    logic        timeout_err;
    logic        model_busy;
    logic        force_busy;

    logic [1:0]  req_g;
    logic [15:0] req_data_g;
    logic [1:0]  ack_g;
    logic        tx_start_g;
    logic [7:0]  tx_data_g;
    logic        tx_busy_g;
    logic        tx_done_g;
    logic        busy_g;
    logic        timeout_g;

    int          total;
    int          bad;
    int          timeout_cnt;
    exp_t        exp_q[$];
    logic [7:0]  src0_q[$];
    logic [7:0]  src1_q[$];
    logic        no_done;
    logic [7:0]  cur_data;
    logic        ack_prev;

    assign tx_busy   = model_busy | force_busy;
    assign tx_busy_g = 1'b0;

    uart_tx_scheduler #(
        .NUM_REQ        (2),
        .GAP_CYCLES     (0),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    uart_tx_scheduler #(
        .NUM_REQ        (2),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (300)
    ) dut_g (
        .clk         (clk),
        .reset       (reset),
        .req         (req_g),
        .req_data    (req_data_g),
        .ack         (ack_g),
        .tx_start    (tx_start_g),
        .tx_data     (tx_data_g),
        .tx_busy     (tx_busy_g),
        .tx_done     (tx_done_g),
        .busy        (busy_g),
        .timeout_err (timeout_g)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input int src, input logic [7:0] data);
        exp_t e;
        e.src  = src;
        e.data = data;
        exp_q.push_back(e);
        if (src == 0) src0_q.push_back(data);
        else          src1_q.push_back(data);
    endtask

    function automatic bit condMet(input int code);
        case (code)
            0:       return req[0];
            1:       return ack != 2'b00;
            2:       return tx_start;
            3:       return timeout_err;
            4:       return (exp_q.size() == 0) && !busy && !tx_busy;
            5:       return ack_g != 2'b00;
            6:       return tx_start_g;
            default: return 1'b0;
        endcase
    endfunction

    task automatic waitFor(input string tag, input int code, input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!condMet(code) && cycles < budget);
        if (!condMet(code)) checkOutput({tag, "_expired"}, 32'd0, 32'd1);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Sources: present the head of their queue, advance just after an ack.
    initial begin
        logic [7:0] dummy;
        req      = 2'b00;
        req_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (ack[0] && src0_q.size() > 0) dummy = src0_q.pop_front();
            if (ack[1] && src1_q.size() > 0) dummy = src1_q.pop_front();
            req[0] = (src0_q.size() > 0);
            req[1] = (src1_q.size() > 0);
            req_data = 16'h0000;
            if (req[0]) req_data[7:0]  = src0_q[0];
            if (req[1]) req_data[15:8] = src1_q[0];
        end
    end

    // Transmitter model: busy for TX_LAT cycles after tx_start, then one tx_done pulse.
    initial begin
        bit aborted;
        model_busy = 1'b0;
        tx_done    = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && reset && !no_done) begin
                model_busy = 1'b1;
                aborted    = 1'b0;
                for (int i = 0; i < TX_LAT; i++) begin
                    @(negedge clk);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    checkOutput("data_hold", 32'(tx_data), 32'(cur_data));
                    tx_done    = 1'b1;
                    model_busy = 1'b0;
                    @(negedge clk);
                    tx_done = 1'b0;
                    checkOutput("busy_fall", 32'(busy), 32'd0);
                end else begin
                    model_busy = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor for the main instance.
    initial begin
        exp_t e;
        ack_prev    = 1'b0;
        timeout_cnt = 0;
        cur_data    = 8'h00;
        forever begin
            @(negedge clk);
            if (timeout_err) timeout_cnt++;
            if (tx_start) begin
                checkOutput("start_after_ack", 32'(ack_prev), 32'd1);
                checkOutput("start_data", 32'(tx_data), 32'(cur_data));
            end
            ack_prev = 1'b0;
            if (ack != 2'b00) begin
                ack_prev = 1'b1;
                if (exp_q.size() == 0) begin
                    checkOutput("ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("ack_src", 32'(ack), 32'd1 << e.src);
                    checkOutput("ack_data", 32'(tx_data), 32'(e.data));
                    cur_data = e.data;
                end
            end
        end
    end

    initial begin
        int cyc;
        int quiet;
        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        force_busy = 1'b0;
        no_done    = 1'b0;
        req_g      = 2'b00;
        req_data_g = 16'h0000;
        tx_done_g  = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_start", 32'(tx_start), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_data", 32'(tx_data), 32'd0);
        checkOutput("rst_tout", 32'(timeout_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single request: ack one cycle after req appears, tx_start one cycle later.
        applyStimulus(0, 8'h0A);
        waitFor("single_req", 0, 10, cyc);
        waitFor("single_ack", 1, 10, cyc);
        checkOutput("single_ack_lat", 32'(cyc), 32'd1);
        waitFor("single_start", 2, 10, cyc);
        checkOutput("single_start_lat", 32'(cyc), 32'd1);
        waitFor("single_drain", 4, 500, cyc);

        // Contention from reset: rr_ptr starts at 0, so the order alternates 0,1,0,1.
        applyReset();
        applyStimulus(0, 8'h14);
        applyStimulus(1, 8'h1E);
        applyStimulus(0, 8'h14);
        applyStimulus(1, 8'h1E);
        waitFor("contention_drain", 4, 1000, cyc);

        // Blocked transmitter holds off the grant until tx_busy falls.
        force_busy = 1'b1;
        applyStimulus(0, 8'h64);
        applyStimulus(0, 8'hC8);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack != 2'b00 || tx_start) quiet++;
        end
        checkOutput("blocked_quiet", 32'(quiet), 32'd0);
        force_busy = 1'b0;
        waitFor("blocked_ack", 1, 10, cyc);
        checkOutput("blocked_ack_lat", 32'(cyc), 32'd1);
        waitFor("blocked_drain", 4, 1000, cyc);

        // Reset mid-frame clears every output without waiting for a clock edge.
        applyStimulus(0, 8'h77);
        waitFor("midrst_start", 2, 10, cyc);
        repeat (5) @(negedge clk);
        applyStimulus(1, 8'h99);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_data", 32'(tx_data), 32'd0);
        checkOutput("midrst_ack", 32'(ack), 32'd0);
        checkOutput("midrst_start", 32'(tx_start), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        waitFor("midrst_drain", 4, 1000, cyc);

        // Watchdog: no tx_done for 0xFF; timeout fires TOUT cycles after tx_start.
        no_done = 1'b1;
        applyStimulus(0, 8'hFF);
        waitFor("wd_start", 2, 10, cyc);
        applyStimulus(1, 8'h5A);
        waitFor("wd_timeout", 3, TOUT + 20, cyc);
        checkOutput("wd_timeout_lat", 32'(cyc), 32'(TOUT));
        checkOutput("wd_idle", 32'(busy), 32'd0);
        no_done = 1'b0;
        waitFor("wd_drain", 4, 1000, cyc);

        // Gap instance: two queued sources, then a re-request arriving during the gap.
        req_g      = 2'b11;
        req_data_g = {8'h22, 8'h11};
        waitFor("gap_ack0", 5, 10, cyc);
        checkOutput("gap_ack0_src", 32'(ack_g), 32'd1);
        checkOutput("gap_ack0_data", 32'(tx_data_g), 32'h11);
        req_g = 2'b10;
        waitFor("gap_start0", 6, 10, cyc);
        repeat (5) @(negedge clk);
        tx_done_g = 1'b1;
        @(negedge clk);
        tx_done_g        = 1'b0;
        req_g            = 2'b11;
        req_data_g[7:0]  = 8'h33;
        @(negedge clk);
        checkOutput("gap_busy", 32'(busy_g), 32'd1);
        waitFor("gap_ack1", 5, 200, cyc);
        checkOutput("gap_len", 32'(cyc + 2), 32'(GAP + 2));
        checkOutput("gap_ack1_src", 32'(ack_g), 32'd2);
        checkOutput("gap_ack1_data", 32'(tx_data_g), 32'h22);
        req_g = 2'b01;
        waitFor("gap_start1", 6, 10, cyc);
        repeat (5) @(negedge clk);
        tx_done_g = 1'b1;
        @(negedge clk);
        tx_done_g = 1'b0;
        waitFor("gap_ack2", 5, 200, cyc);
        checkOutput("gap_ack2_src", 32'(ack_g), 32'd1);
        checkOutput("gap_ack2_data", 32'(tx_data_g), 32'h33);
        req_g = 2'b00;

        checkOutput("timeout_count", 32'(timeout_cnt), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
